// File: rtl/io_bus_pkg.sv
// Shared types and constants for the board IO access controller.
package io_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } io_state_t;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'hF000_0000;

    localparam logic [7:0] OFF_HEX      = 8'h00;
    localparam logic [7:0] OFF_LEDR     = 8'h04;
    localparam logic [7:0] OFF_LEDG     = 8'h08;
    localparam logic [7:0] OFF_KEYS     = 8'h10;
    localparam logic [7:0] OFF_SWITCHES = 8'h14;

endpackage

// File: rtl/io_rr_arbiter.sv
// Two-way round-robin arbiter; the last-grant bit resets to 1 so port 0 wins the first tie.
module io_rr_arbiter (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic accept,
    output logic gnt
);

    logic last;

    // A lone requester always wins; on a tie the port not granted last wins.
    always_comb begin
        gnt = req1;
        if (req0 && req1) begin
            gnt = ~last;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last <= 1'b1;
        end else if (accept) begin
            last <= gnt;
        end
    end

endmodule

// File: rtl/io_bus_ctrl.sv
// Memory-mapped IO access controller: arbitrates two requesters, decodes, strobes, responds.
// Optional IOCTRL_ERR_EN adds per-port error flags and a saturating error counter.
module io_bus_ctrl
    import io_bus_pkg::*;
#(
    parameter int                        DATA_BIT_WIDTH = 32,
    parameter logic [DATA_BIT_WIDTH-1:0] IO_BASE        = IO_BASE_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req0_valid,
    input  logic                      req0_we,
    input  logic [DATA_BIT_WIDTH-1:0] req0_addr,
    input  logic [DATA_BIT_WIDTH-1:0] req0_wdata,
    output logic                      req0_ready,
    output logic                      rsp0_valid,
    output logic [DATA_BIT_WIDTH-1:0] rsp0_rdata,
    input  logic                      req1_valid,
    input  logic                      req1_we,
    input  logic [DATA_BIT_WIDTH-1:0] req1_addr,
    input  logic [DATA_BIT_WIDTH-1:0] req1_wdata,
    output logic                      req1_ready,
    output logic                      rsp1_valid,
    output logic [DATA_BIT_WIDTH-1:0] rsp1_rdata,
    output logic                      isHex,
    output logic                      isLedr,
    output logic                      isLedg,
    output logic                      isSwitches,
    output logic [DATA_BIT_WIDTH-1:0] dataOut,
`ifdef IOCTRL_ERR_EN
    output logic                      rsp0_err,
    output logic                      rsp1_err,
    output logic [7:0]                err_count,
`endif
    input  logic [DATA_BIT_WIDTH-1:0] ioIn
);

    io_state_t                 state, next_state;
    logic                      gnt, accept;
    logic                      lat_port, lat_we;
    logic [DATA_BIT_WIDTH-1:0] lat_addr, rdata;
    logic [7:0]                offset;
    logic                      base_hit;
    logic                      wr_hex, wr_ledr, wr_ledg, rd_keys, rd_sw, acc_ok;

    io_rr_arbiter u_arb (
        .clk    (clk),
        .reset  (reset),
        .req0   (req0_valid),
        .req1   (req1_valid),
        .accept (accept),
        .gnt    (gnt)
    );

    // Every mapped offset is word aligned, so a misaligned address can never match one.
    assign offset   = lat_addr[7:0];
    assign base_hit = (lat_addr[DATA_BIT_WIDTH-1:8] == IO_BASE[DATA_BIT_WIDTH-1:8]);
    assign wr_hex   = base_hit &&  lat_we && (offset == OFF_HEX);
    assign wr_ledr  = base_hit &&  lat_we && (offset == OFF_LEDR);
    assign wr_ledg  = base_hit &&  lat_we && (offset == OFF_LEDG);
    assign rd_keys  = base_hit && !lat_we && (offset == OFF_KEYS);
    assign rd_sw    = base_hit && !lat_we && (offset == OFF_SWITCHES);
    assign acc_ok   = wr_hex || wr_ledr || wr_ledg || rd_keys || rd_sw;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Ready is gated by reset so nothing is offered while reset is held low.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                if ((req0_valid || req1_valid) && reset) begin
                    accept     = 1'b1;
                    req0_ready = ~gnt;
                    req1_ready = gnt;
                    next_state = ACCESS;
                end
            end
            ACCESS:  next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_port <= 1'b0;
            lat_we   <= 1'b0;
            lat_addr <= '0;
            dataOut  <= '0;
            rdata    <= '0;
        end else begin
            if (accept) begin
                lat_port <= gnt;
                lat_we   <= gnt ? req1_we    : req0_we;
                lat_addr <= gnt ? req1_addr  : req0_addr;
                dataOut  <= gnt ? req1_wdata : req0_wdata;
            end
            if (state == ACCESS) begin
                rdata <= (rd_keys || rd_sw) ? ioIn : '0;
            end
        end
    end

    assign isHex      = (state == ACCESS) && wr_hex;
    assign isLedr     = (state == ACCESS) && wr_ledr;
    assign isLedg     = (state == ACCESS) && wr_ledg;
    assign isSwitches = (state == ACCESS) && rd_sw;

    assign rsp0_valid = (state == RESP) && !lat_port;
    assign rsp1_valid = (state == RESP) &&  lat_port;
    assign rsp0_rdata = rdata;
    assign rsp1_rdata = rdata;

`ifdef IOCTRL_ERR_EN
    assign rsp0_err = rsp0_valid && !acc_ok;
    assign rsp1_err = rsp1_valid && !acc_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count <= '0;
        end else if ((state == RESP) && !acc_ok && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Self-checking bench for io_bus_ctrl: vector table, round-robin run, mid-access reset.
module tb_io_bus_ctrl;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] ioin;
        logic [2:0]  strobe;
        logic        sw;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_we, req0_ready, rsp0_valid;
    logic [31:0] req0_addr, req0_wdata, rsp0_rdata;
    logic        req1_valid, req1_we, req1_ready, rsp1_valid;
    logic [31:0] req1_addr, req1_wdata, rsp1_rdata;
    logic        isHex, isLedr, isLedg, isSwitches;
    logic [31:0] dataOut, ioIn;
`ifdef IOCTRL_ERR_EN
    logic        rsp0_err, rsp1_err;
    logic [7:0]  err_count;
`endif

    int   checks    = 0;
    int   failures  = 0;
    int   exp_errs  = 0;
    exp_t sb[$];
    vec_t vecs[11];

    always #5 clk = ~clk;

    io_bus_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_ready (req0_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .req1_valid (req1_valid),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_ready (req1_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .isHex      (isHex),
        .isLedr     (isLedr),
        .isLedg     (isLedg),
        .isSwitches (isSwitches),
        .dataOut    (dataOut),
`ifdef IOCTRL_ERR_EN
        .rsp0_err   (rsp0_err),
        .rsp1_err   (rsp1_err),
        .err_count  (err_count),
`endif
        .ioIn       (ioIn)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input logic p, input logic v, input logic we,
                           input logic [31:0] a, input logic [31:0] d);
        if (p) begin
            req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
        end else begin
            req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
        end
    endtask

    task automatic push_exp(input logic p, input logic [31:0] rd, input logic err);
        exp_t e;
        e.port  = p;
        e.rdata = rd;
        e.err   = err;
        sb.push_back(e);
        if (err) exp_errs++;
    endtask

    // Scoreboard: every response pulse must match the oldest accepted request.
    always @(negedge clk) begin
        exp_t e;
        if (rsp0_valid || rsp1_valid) begin
            chk("rsp_onehot", {31'b0, rsp0_valid & rsp1_valid}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected actual=rsp0:%0b rsp1:%0b required=none at %0t",
                         rsp0_valid, rsp1_valid, $time);
            end else begin
                e = sb.pop_front();
                chk("rsp_port", {31'b0, rsp1_valid}, {31'b0, e.port});
                chk("rsp_rdata", e.port ? rsp1_rdata : rsp0_rdata, e.rdata);
`ifdef IOCTRL_ERR_EN
                chk("rsp_err", {31'b0, e.port ? rsp1_err : rsp0_err}, {31'b0, e.err});
`endif
            end
        end
    end

    task automatic do_access(input vec_t v);
        int n;
        @(negedge clk);
        ioIn = v.ioin;
        set_req(v.port, 1'b1, v.we, v.addr, v.wdata);
        #1;
        n = 0;
        while (!(v.port ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("ready", {31'b0, v.port ? req1_ready : req0_ready}, 32'd1);
        chk("ready_other", {31'b0, v.port ? req0_ready : req1_ready}, 32'd0);
        push_exp(v.port, v.rdata, v.err);
        @(negedge clk);
        set_req(v.port, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("strobe", {29'b0, isHex, isLedr, isLedg}, {29'b0, v.strobe});
        chk("isSwitches", {31'b0, isSwitches}, {31'b0, v.sw});
        if (v.we) chk("dataOut", dataOut, v.wdata);
        chk("rsp_early", {30'b0, rsp0_valid, rsp1_valid}, 32'd0);
        @(negedge clk); #1;
        chk("rsp_timing", {31'b0, v.port ? rsp1_valid : rsp0_valid}, 32'd1);
        chk("strobe_after", {28'b0, isHex, isLedr, isLedg, isSwitches}, 32'd0);
        @(negedge clk); #1;
`ifdef IOCTRL_ERR_EN
        chk("err_count", {24'b0, err_count}, exp_errs);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c, last_c, grants;
        logic exp_p;

        vecs[0]  = '{1'b0, 1'b1, 32'hF000_0000, 32'h7F3F_067F, 32'h0,         3'b100, 1'b0, 32'h0,         1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'hF000_0014, 32'h0,         32'h0000_02A5, 3'b000, 1'b1, 32'h0000_02A5, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 32'hF000_0010, 32'h0,         32'h0000_000F, 3'b000, 1'b0, 32'h0000_000F, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 32'hF000_0008, 32'h0000_0055, 32'h0,         3'b001, 1'b0, 32'h0,         1'b0};
        vecs[4]  = '{1'b0, 1'b1, 32'hF000_0004, 32'h0000_03FF, 32'h0,         3'b010, 1'b0, 32'h0,         1'b0};
        vecs[5]  = '{1'b0, 1'b1, 32'hF000_0010, 32'h1234_5678, 32'h0,         3'b000, 1'b0, 32'h0,         1'b1};
        vecs[6]  = '{1'b1, 1'b0, 32'hF000_000C, 32'h0,         32'h0000_FFFF, 3'b000, 1'b0, 32'h0,         1'b1};
        vecs[7]  = '{1'b0, 1'b1, 32'hF000_0006, 32'hDEAD_BEEF, 32'h0,         3'b000, 1'b0, 32'h0,         1'b1};
        vecs[8]  = '{1'b1, 1'b0, 32'hF000_0000, 32'h0,         32'h0000_1234, 3'b000, 1'b0, 32'h0,         1'b1};
        vecs[9]  = '{1'b0, 1'b1, 32'hE000_0004, 32'h0000_00AA, 32'h0,         3'b000, 1'b0, 32'h0,         1'b1};
        vecs[10] = '{1'b1, 1'b0, 32'hF000_0014, 32'h0,         32'hFFFF_FFFF, 3'b000, 1'b1, 32'hFFFF_FFFF, 1'b0};

        reset = 1'b0;
        ioIn  = 32'h0;
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1'b1, 1'b1, 1'b1, 32'hF000_0000, 32'h1);
        #12;
        chk("rst_strobes", {28'b0, isHex, isLedr, isLedg, isSwitches}, 32'd0);
        chk("rst_ready", {30'b0, req0_ready, req1_ready}, 32'd0);
        chk("rst_rsp", {30'b0, rsp0_valid, rsp1_valid}, 32'd0);
        chk("rst_dataOut", dataOut, 32'd0);
        chk("rst_rdata", rsp0_rdata, 32'd0);
`ifdef IOCTRL_ERR_EN
        chk("rst_err_count", {24'b0, err_count}, 32'd0);
`endif
        set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 11; i++) do_access(vecs[i]);

        // Both ports request LEDR continuously from reset: expect 0,1,0,1 three cycles apart.
        @(negedge clk);
        reset    = 1'b0;
        exp_errs = 0;
        set_req(1'b0, 1'b1, 1'b1, 32'hF000_0004, 32'h0000_00A0);
        set_req(1'b1, 1'b1, 1'b1, 32'hF000_0004, 32'h0000_00B1);
        @(negedge clk);
        reset  = 1'b1;
        #1;
        c      = 0;
        last_c = 0;
        grants = 0;
        while (grants < 4 && c < 40) begin
            if (req0_ready || req1_ready) begin
                exp_p = grants[0];
                chk("rr_both_ready", {31'b0, req0_ready & req1_ready}, 32'd0);
                chk("rr_port", {31'b0, req1_ready}, {31'b0, exp_p});
                chk("rr_gap", c, (grants == 0) ? 0 : last_c + 3);
                push_exp(req1_ready, 32'h0, 1'b0);
                last_c = c;
                grants++;
            end
            @(negedge clk); #1; c++;
        end
        chk("rr_grants", grants, 32'd4);
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (4) @(negedge clk);

        // Reset during the ACCESS cycle of a LEDG write drops it without a response.
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b1, 32'hF000_0008, 32'h0000_003C);
        #1;
        chk("rst_mid_ready", {31'b0, req0_ready}, 32'd1);
        @(negedge clk);
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("rst_mid_ledg_on", {31'b0, isLedg}, 32'd1);
        #1;
        reset    = 1'b0;
        exp_errs = 0;
        #1;
        chk("rst_mid_ledg_off", {31'b0, isLedg}, 32'd0);
        chk("rst_mid_dataOut", dataOut, 32'd0);
        set_req(1'b1, 1'b1, 1'b1, 32'hF000_0000, 32'h0000_0666);
        #1;
        chk("rst_mid_no_ready", {30'b0, req0_ready, req1_ready}, 32'd0);
        @(negedge clk); #1;
        chk("rst_mid_no_rsp", {30'b0, rsp0_valid, rsp1_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_first_grant", {31'b0, req1_ready}, 32'd1);
        push_exp(1'b1, 32'h0, 1'b0);
        @(negedge clk);
        set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("rst_after_hex", {29'b0, isHex, isLedr, isLedg}, 32'd4);
        chk("rst_after_data", dataOut, 32'h0000_0666);
        @(negedge clk); #1;
        chk("rst_after_rsp", {31'b0, rsp1_valid}, 32'd1);

        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_bus_ctrl.md
Name: io_bus_ctrl

Overview:
- Memory-mapped access controller in front of the board IO block (HEX, LEDR, LEDG, switches, keys).
- Arbitrates two word-wide requesters: port 0 is the CPU data port, port 1 is the debug/loader port.
- Decodes the address, sequences each access, and generates the one-hot IO strobes and the read-select.
- Returns a registered response to the granted requester.

Parameters:
- DATA_BIT_WIDTH, 32, width of address and data words.
- IO_BASE, 32'hF000_0000, base of the IO window; bits [31:8] must match.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req0_valid  in  1  port 0 request.
- req0_we  in  1  port 0 write (1) / read (0).
- req0_addr  in  DATA_BIT_WIDTH  port 0 byte address.
- req0_wdata  in  DATA_BIT_WIDTH  port 0 write data.
- req0_ready  out  1  port 0 request accepted this cycle.
- rsp0_valid  out  1  port 0 response pulse.
- rsp0_rdata  out  DATA_BIT_WIDTH  port 0 read data.
- req1_*/rsp1_*  same set for port 1.
- isHex, isLedr, isLedg  out  1  IO write strobes.
- isSwitches  out  1  IO read select (1 = switches, 0 = keys).
- dataOut  out  DATA_BIT_WIDTH  write data to IO.
- ioIn  in  DATA_BIT_WIDTH  read data from IO, combinational from the IO registers.

Behaviour:
- Address map (offset = addr[7:0], word aligned):
  - 0x00 HEX (W)
  - 0x04 LEDR (W)
  - 0x08 LEDG (W)
  - 0x10 KEYS (R)
  - 0x14 SWITCHES (R)
  - Anything else, a non-matching base, or addr[1:0] != 0 is unmapped.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: if any req_valid, grant one requester, pulse its req_ready, latch we/addr/wdata/port, go to ACCESS.
  - ACCESS:
    - Write to a mapped W offset: exactly one strobe high for this single cycle; dataOut = latched wdata.
    - Read: isSwitches = (offset == 0x14); capture ioIn into the rdata register at the clock edge.
    - Go to RESP.
  - RESP: rsp_valid of the latched port high for one cycle with rdata stable; go to IDLE.
- Latency:
  - Accept at edge N (ready high during cycle N).
  - Strobe during cycle N+1; response during cycle N+2.
  - Next accept no earlier than cycle N+3, giving a throughput of one access per 3 cycles.
- Arbitration: round-robin on a last-grant bit.
  - Both valid: grant the port that was not granted last.
  - One valid: grant it regardless of the last-grant bit.
  - Reset value of last-grant = 1, so port 0 wins the first tie.
- Handshake:
  - req_ready is only asserted in IDLE, for the granted port.
  - Requesters hold valid and payload until ready.
  - rsp is a pulse with no back-pressure.
- Unmapped or wrong-direction access:
  - Writes to R offsets and reads of W offsets count as wrong-direction.
  - No strobe is raised; a read returns 0; a response is still produced with normal timing.
- Read data: KEYS/SWITCHES values are zero-extended exactly as presented on ioIn.
- Outputs:
  - All strobes low except in ACCESS.
  - isSwitches is 0 outside ACCESS-reads.
  - dataOut is registered (latched wdata).
- Reset (asynchronous, any state, including mid-ACCESS):
  - State = IDLE.
  - All strobes, ready, rsp_valid = 0.
  - rdata, dataOut = 0.
  - Pending access dropped and no response issued.
  - First grant possible in the first cycle after deassertion.

Optional Feature:
- IOCTRL_ERR_EN.
- Defined:
  - Adds outputs rsp0_err and rsp1_err (1 bit each), valid with rsp_valid.
  - The bit is 1 for an unmapped, misaligned or wrong-direction access.
  - Adds err_count (8 bits, saturating at 255, cleared by reset), incremented once per erroring access in RESP.
- Undefined: these ports and the counter do not exist; error cases behave identically otherwise.

Decomposition:
- Shared package io_bus_pkg:
  - FSM state enum (IDLE, ACCESS, RESP).
  - Offset constants (OFF_HEX, OFF_LEDR, OFF_LEDG, OFF_KEYS, OFF_SWITCHES).
  - IO_BASE default.
- One natural sub-module: io_rr_arbiter, a 2-way round-robin arbiter with a last-grant register.
- Decode and FSM stay in the top module.

Test Plan:
- Port 0 write 0x00 data 0x7F3F067F → isHex high exactly in cycle N+1, dataOut = 0x7F3F067F, rsp0_valid at N+2, no other strobe.
- Port 1 read 0x14 with ioIn = 0x000002A5 in ACCESS → isSwitches = 1 in N+1, rsp1_rdata = 0x000002A5 at N+2.
- Both ports continuously write LEDR (0x04) after reset → grants 0,1,0,1, each ready pulse 3 cycles apart, port 0 first.
- Write to 0x10 and read 0x0C → no strobe; read returns 0; with IOCTRL_ERR_EN, rsp_err = 1 and err_count = 2.
- Assert reset low during ACCESS of a LEDG write → isLedg drops immediately, no rsp_valid; after release, a new request is accepted in the first cycle.
- Misaligned write 0xF0000006 → no strobe, response issued at N+2.
